// File: rtl/dcache_dual_arbiter_pkg.sv
// Shared types for the dual-slot data-cache arbiter:
// slot ids, grant FSM encoding and the request bundle.
package dcache_dual_arbiter_pkg;

  localparam logic DCACHE_SLOT_01 = 1'b0;
  localparam logic DCACHE_SLOT_02 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD01 = 2'd1,
    ARB_HOLD02 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dc_req_t;

  function automatic arb_state_e hold_of(logic slot);
    return (slot == DCACHE_SLOT_02) ? ARB_HOLD02 : ARB_HOLD01;
  endfunction

endpackage

// File: rtl/dcache_dual_arbiter_order.sv
// In-order tag FIFO: remembers which slot owns each
// outstanding cache request (1-bit payload).
module dcache_order_fifo
  import dcache_dual_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q];

  // next pointers, count and storage
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dcache_dual_arbiter.sv
// Shares one data-cache port between the two memory slots.
// Optional perf counters: define DCACHE_ARB_PERF_EN.
module dcache_dual_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef DCACHE_ARB_PERF_EN
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_full_cnt,
`endif
  input  logic        s01_req,
  input  logic        s01_wr,
  input  logic [1:0]  s01_size,
  input  logic [31:0] s01_addr,
  input  logic [3:0]  s01_wstrb,
  input  logic [31:0] s01_wdata,
  output logic        s01_addr_ok,
  input  logic        s02_req,
  input  logic        s02_wr,
  input  logic [1:0]  s02_size,
  input  logic [31:0] s02_addr,
  input  logic [3:0]  s02_wstrb,
  input  logic [31:0] s02_wdata,
  output logic        s02_addr_ok,
  output logic        data_cache_data_ok_01,
  output logic [31:0] data_cache_rdata_01,
  output logic        data_cache_data_ok_02,
  output logic [31:0] data_cache_rdata_02,
  output logic        cache_req,
  output logic        cache_wr,
  output logic [1:0]  cache_size,
  output logic [31:0] cache_addr,
  output logic [3:0]  cache_wstrb,
  output logic [31:0] cache_wdata,
  input  logic        cache_addr_ok,
  input  logic        cache_data_ok,
  input  logic [31:0] cache_rdata
);

  import dcache_dual_arbiter_pkg::*;

  arb_state_e state_q, state_d;
  dc_req_t    s01_r, s02_r, gnt_r;
  logic       gnt_vld, gnt_slot, accept;
  logic       fifo_head, fifo_empty, fifo_full;
  logic       ret_vld;

  assign s01_r = {s01_wr, s01_size, s01_addr,
                  s01_wstrb, s01_wdata};
  assign s02_r = {s02_wr, s02_size, s02_addr,
                  s02_wstrb, s02_wdata};

  // pick the slot owning the request mux; older slot first
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_slot = DCACHE_SLOT_01;
    unique case (state_q)
      ARB_IDLE: begin
        if (s01_req) begin
          gnt_vld  = 1'b1;
          gnt_slot = DCACHE_SLOT_01;
        end else if (s02_req) begin
          gnt_vld  = 1'b1;
          gnt_slot = DCACHE_SLOT_02;
        end
      end
      ARB_HOLD01: begin
        gnt_vld  = s01_req;
        gnt_slot = DCACHE_SLOT_01;
      end
      ARB_HOLD02: begin
        gnt_vld  = s02_req;
        gnt_slot = DCACHE_SLOT_02;
      end
      default: begin
        gnt_vld  = 1'b0;
        gnt_slot = DCACHE_SLOT_01;
      end
    endcase
  end

  assign gnt_r = (gnt_slot == DCACHE_SLOT_02) ? s02_r : s01_r;

  // a full tag FIFO blocks issue, even on a same-cycle pop
  assign cache_req = resetn & gnt_vld & ~fifo_full;
  assign accept    = cache_req & cache_addr_ok;

  assign {cache_wr, cache_size, cache_addr,
          cache_wstrb, cache_wdata} = resetn ? gnt_r : '0;

  assign s01_addr_ok = accept & (gnt_slot == DCACHE_SLOT_01);
  assign s02_addr_ok = accept & (gnt_slot == DCACHE_SLOT_02);

  // keep the grant locked until the cache takes it
  always_comb begin
    state_d = ARB_IDLE;
    if (gnt_vld && !accept) begin
      state_d = hold_of(gnt_slot);
    end
  end

  // grant state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  dcache_order_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_order (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .din    (gnt_slot),
    .pop    (cache_data_ok),
    .head   (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // responses with nothing outstanding are dropped
  assign ret_vld = resetn & cache_data_ok & ~fifo_empty;

  assign data_cache_data_ok_01 =
    ret_vld & (fifo_head == DCACHE_SLOT_01);
  assign data_cache_data_ok_02 =
    ret_vld & (fifo_head == DCACHE_SLOT_02);
  assign data_cache_rdata_01 = resetn ? cache_rdata : '0;
  assign data_cache_rdata_02 = resetn ? cache_rdata : '0;

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt_q, perf_conflict_cnt_d;
  logic [31:0] perf_full_cnt_q, perf_full_cnt_d;

  // free-running event counters
  always_comb begin
    perf_conflict_cnt_d = perf_conflict_cnt_q;
    perf_full_cnt_d     = perf_full_cnt_q;
    if (state_q == ARB_IDLE && s01_req && s02_req) begin
      perf_conflict_cnt_d = perf_conflict_cnt_q + 32'd1;
    end
    if (gnt_vld && fifo_full) begin
      perf_full_cnt_d = perf_full_cnt_q + 32'd1;
    end
  end

  // perf counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_conflict_cnt_q <= '0;
      perf_full_cnt_q     <= '0;
    end else begin
      perf_conflict_cnt_q <= perf_conflict_cnt_d;
      perf_full_cnt_q     <= perf_full_cnt_d;
    end
  end

  assign perf_conflict_cnt = perf_conflict_cnt_q;
  assign perf_full_cnt     = perf_full_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_orphan_rsp : assert property (
    @(posedge clk) disable iff (!resetn)
    cache_data_ok |-> !fifo_empty
  );
`endif

endmodule

// File: doc/dcache_dual_arbiter.md
# dcache_dual_arbiter

Shares the single-ported data-cache request interface between the two memory slots of the dual-issue pipeline (slot 01 = older instruction, slot 02 = younger). It sits between the pre-MEM stage and the data cache. It grants slot 01 ahead of slot 02 and holds a grant stable until the cache accepts it. An in-order tag FIFO records which slot owns each outstanding request, so it can steer `data_ok`/`rdata` back as `data_cache_data_ok_01`/`_02` and `data_cache_rdata_01`/`_02` for the MEM stage.

## Interface
Parameters:
- OUTSTANDING, 2: maximum accepted-but-unanswered cache requests; power of two, ≥1.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - resetn  in  1  asynchronous active-low reset
- Slot x requests (x ∈ {01, 02}):
  - sx_req  in  1  request valid; held until sx_addr_ok
  - sx_wr  in  1  1 = store
  - sx_size  in  2  0/1/2 = byte/half/word
  - sx_addr  in  32  byte address
  - sx_wstrb  in  4  byte enables
  - sx_wdata  in  32  store data
  - sx_addr_ok  out  1  request accepted this cycle
- Returns to MEM stage (x ∈ {01, 02}):
  - data_cache_data_ok_x  out  1  response for slot x
  - data_cache_rdata_x  out  32  read data for slot x
- Cache side:
  - cache_req, cache_wr, cache_size, cache_addr, cache_wstrb, cache_wdata  out  1/1/2/32/4/32  muxed request
  - cache_addr_ok  in  1  cache accepts the request
  - cache_data_ok  in  1  in-order response
  - cache_rdata  in  32  response data
- Perf counters (only with DCACHE_ARB_PERF_EN):
  - perf_conflict_cnt  out  32  count of cycles where a conflict occurred
  - perf_full_cnt  out  32  count of cycles stalled on a full FIFO

## Operation
- Grant FSM states and transitions:
  - IDLE:
    - s01_req → grant 01; else s02_req → grant 02.
    - A grant presented with cache_addr_ok=0 moves to HOLD01 or HOLD02.
  - HOLDx: request mux locked to slot x.
    - Returns to IDLE on cache_req & cache_addr_ok.
    - Slot 01 rising during HOLD02 does not preempt.
- Request gating:
  - cache_req = granted slot's req & ~fifo_full.
  - When full, cache_req=0 and the FSM stays (or enters) HOLDx for the granted slot; the grant is not released.
  - A full FIFO blocks issue even if cache_data_ok pops in the same cycle (no full-bypass path).
- sx_addr_ok = cache_addr_ok & cache_req & grant==x.
- Tag FIFO:
  - Push slot id on cache_req & cache_addr_ok; pop on cache_data_ok.
  - Simultaneous push+pop keeps the count unchanged.
  - Pointers wrap modulo OUTSTANDING.
- Return steering:
  - data_cache_data_ok_x = cache_data_ok & fifo_head==x & ~fifo_empty.
  - Both rdata outputs = cache_rdata.
  - Store responses are also routed, because MEM waits on data_ok for stores.
- cache_data_ok with an empty FIFO is a protocol error: ignored, no output pulse; flagged by a simulation assertion.
- Slot 01 may starve slot 02 indefinitely. This is intended, since program order requires the older instruction first.

## Timing
- Request path is combinational, zero latency: sx_req → cache_req in the same cycle.
- Response path is combinational, zero latency: cache_data_ok → data_cache_data_ok_x in the same cycle.
- Same-cycle s01_req & s02_req:
  - Slot 01 is accepted in cycle N at the earliest.
  - Slot 02 is accepted in cycle N+1 at the earliest.
- Reset values:
  - FSM=IDLE, FIFO empty, counters 0.
  - All outputs 0, including cache_req, sx_addr_ok, data_ok and rdata mux select.
  - Cache-side data buses are don't-care while cache_req=0.
- Reset mid-operation: outstanding tags are dropped. The cache is reset by the same resetn, so no orphan responses are expected.

## Configuration
- DCACHE_ARB_PERF_EN defined:
  - perf_conflict_cnt increments on IDLE & s01_req & s02_req.
  - perf_full_cnt increments on granted req & fifo_full.
  - Both are free-running and wrap at 2^32.
- Undefined: the perf ports and registers do not exist.

## Structure
- Shared header mycpu.h holds:
  - DCACHE_SLOT_01 = 1'b0, DCACHE_SLOT_02 = 1'b1;
  - grant FSM state encodings (IDLE=2'd0, HOLD01=2'd1, HOLD02=2'd2).
- Sub-module dcache_order_fifo:
  - parameterised depth, 1-bit payload;
  - push/pop/head/empty/full.

## Test plan
- Single lw from slot 01, cache_addr_ok same cycle, data_ok 3 cycles later with rdata=0x12345678:
  - s01_addr_ok at cycle 0;
  - data_cache_data_ok_01 at cycle 3 with rdata 0x12345678;
  - _02 never pulses.
- Both slots request in cycle 0, cache_addr_ok always 1, responses 0xA then 0xB:
  - slot 01 accepted cycle 0, slot 02 accepted cycle 1;
  - data_ok_01 carries 0xA, then data_ok_02 carries 0xB.
- Slot 02 alone with cache_addr_ok=0 for 4 cycles, s01_req rising at cycle 2:
  - cache_addr stays slot 02's address until acceptance at cycle 4;
  - slot 01 is accepted at cycle 5.
- OUTSTANDING=2, three back-to-back requests, no data_ok:
  - third held with cache_req=0 until the first data_ok;
  - third issues the following cycle;
  - perf_full_cnt > 0 with DCACHE_ARB_PERF_EN.
- Spurious cache_data_ok with empty FIFO: no data_ok pulse, assertion fires.
- resetn low with two requests outstanding:
  - all outputs 0 asynchronously;
  - after release, a new request tags from FIFO slot 0.
